fetch_sequencer: RTL and testbench

Multi-cycle instruction fetch controller. It assembles each 32-bit instruction from a byte-wide ROM port over a req/ack handshake and presents it to the decoder with a valid/ready handshake. It sits between the instruction pointer register and the decoder, replacing the direct combinational `rom[ip]` lookup. It also sequences fetch restarts on taken jumps and flags out-of-range instruction pointers.

---
 rtl/fetch_sequencer.sv | 130 +++++++++++++
 tb/tb_fetch_sequencer.sv | 383 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_sequencer.sv
// Multi-cycle instruction fetch: assembles a 32-bit word from four byte reads over
// req/ack and holds it for the decoder under valid/ready; restarts on flush, traps bad ip.
module fetch_sequencer #(
  parameter int unsigned addr_size = 16,
  parameter int unsigned rom_size  = 256
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic [addr_size-1:0] ip,
  input  logic                 flush,
  output logic                 mem_req,
  output logic [addr_size+1:0] mem_addr,
  input  logic                 mem_ack,
  input  logic [7:0]           mem_rdata,
  output logic [31:0]          instr,
  output logic                 instr_valid,
  input  logic                 instr_ready,
  output logic                 busy,
  output logic                 fault
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    VALID = 2'd2,
    FAULT = 2'd3
  } state_t;

  state_t               state;
  state_t               state_nx;
  logic [1:0]           count;
  logic [1:0]           count_nx;
  logic [addr_size+1:0] addr_nx;
  logic [31:0]          instr_nx;
  logic                 req_nx;
  logic                 valid_nx;
  logic                 busy_nx;
  logic                 fault_nx;
  logic                 in_range;

  assign in_range = (32'(ip) < rom_size);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state       <= IDLE;
      count       <= '0;
      mem_addr    <= '0;
      instr       <= '0;
      mem_req     <= 1'b0;
      instr_valid <= 1'b0;
      busy        <= 1'b0;
      fault       <= 1'b0;
    end else begin
      state       <= state_nx;
      count       <= count_nx;
      mem_addr    <= addr_nx;
      instr       <= instr_nx;
      mem_req     <= req_nx;
      instr_valid <= valid_nx;
      busy        <= busy_nx;
      fault       <= fault_nx;
    end
  end

  always_comb begin
    state_nx = state;
    count_nx = count;
    addr_nx  = mem_addr;
    instr_nx = instr;
    req_nx   = mem_req;
    valid_nx = instr_valid;
    fault_nx = fault;

    // A taken jump overrides everything except the fault trap; any byte landing now is dropped.
    if (flush && (state != FAULT)) begin
      state_nx = IDLE;
      req_nx   = 1'b0;
      valid_nx = 1'b0;
      count_nx = '0;
    end else begin
      case (state)
        IDLE: begin
          if (!in_range) begin
            state_nx = FAULT;
            fault_nx = 1'b1;
            req_nx   = 1'b0;
            valid_nx = 1'b0;
          end else begin
            state_nx = FETCH;
            addr_nx  = {ip, 2'b00};
            count_nx = '0;
            req_nx   = 1'b1;
            valid_nx = 1'b0;
          end
        end
        FETCH: begin
          if (mem_ack) begin
            // Bytes arrive MSB first, so shift left and append.
            instr_nx = {instr[23:0], mem_rdata};
            count_nx = count + 2'd1;
            addr_nx  = mem_addr + 1'b1;
            if (count == 2'd3) begin
              state_nx = VALID;
              req_nx   = 1'b0;
              valid_nx = 1'b1;
            end
          end
        end
        VALID: begin
          if (instr_ready) begin
            state_nx = IDLE;
            valid_nx = 1'b0;
          end
        end
        FAULT: begin
          req_nx   = 1'b0;
          valid_nx = 1'b0;
        end
        default: begin
          state_nx = IDLE;
          req_nx   = 1'b0;
          valid_nx = 1'b0;
        end
      endcase
    end

    busy_nx = (state_nx == FETCH);
  end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: directed scenarios plus a randomized run checked against
// a transaction-level model built on a byte-array ROM image.
module tb_fetch_sequencer;

  logic        clk;
  logic        rstn;
  logic [15:0] ip;
  logic        flush;
  logic        mem_req;
  logic [17:0] mem_addr;
  logic        mem_ack;
  logic [7:0]  mem_rdata;
  logic [31:0] instr;
  logic        instr_valid;
  logic        instr_ready;
  logic        busy;
  logic        fault;

  logic [7:0]  mem [0:1023];
  int errors;
  int checks;

  fetch_sequencer #(.addr_size(16), .rom_size(256)) dut (
    .clk(clk), .rstn(rstn), .ip(ip), .flush(flush),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .instr(instr), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .busy(busy), .fault(fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] exp_word(input int p);
    return {mem[4*p], mem[4*p+1], mem[4*p+2], mem[4*p+3]};
  endfunction

  // Advance one cycle, then present the ROM byte for the address now on the bus.
  task automatic tick();
    @(posedge clk);
    #1;
    mem_rdata = mem_req ? mem[mem_addr[9:0]] : 8'($urandom);
  endtask

  task automatic wait_req(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (mem_req) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rstn = 1'b0; ip = '0; flush = 1'b0; mem_ack = 1'b0; instr_ready = 1'b0; mem_rdata = '0;
    tick();
    tick();
    checks++;
    if ({mem_req, mem_addr, instr, instr_valid, busy, fault} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got req=%b addr=%h instr=%h vld=%b busy=%b fault=%b, want all 0",
               mem_req, mem_addr, instr, instr_valid, busy, fault);
    end
    rstn = 1'b1;
  endtask

  task automatic test_basic();
    bit ok;
    ip = 16'd0; mem_ack = 1'b1; instr_ready = 1'b1; flush = 1'b0;
    wait_req(ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL basic_start: got no mem_req, want mem_req=1"); end
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (mem_req !== 1'b1 || busy !== 1'b1 || instr_valid !== 1'b0 || mem_addr !== 18'(k)) begin
        errors++;
        $display("FAIL basic_addr%0d: got req=%b busy=%b vld=%b addr=%h, want 1 1 0 %h",
                 k, mem_req, busy, instr_valid, mem_addr, 18'(k));
      end
      tick();
    end
    checks++;
    if (instr_valid !== 1'b1 || instr !== 32'h12345678) begin
      errors++;
      $display("FAIL basic_instr: got vld=%b instr=%h, want 1 12345678", instr_valid, instr);
    end
    checks++;
    if (mem_req !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL basic_req_drop: got req=%b busy=%b, want 0 0", mem_req, busy);
    end
    tick();
    checks++;
    if (instr_valid !== 1'b0) begin
      errors++;
      $display("FAIL basic_consume: got vld=%b, want 0", instr_valid);
    end
  endtask

  task automatic test_wait_states();
    bit ok;
    ip = 16'd5; mem_ack = 1'b0; instr_ready = 1'b1;
    wait_req(ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL wait_start: got no mem_req, want mem_req=1"); end
    for (int n = 1; n <= 12; n++) begin
      checks++;
      if (mem_req !== 1'b1 || instr_valid !== 1'b0 || mem_addr !== 18'(20 + (n - 1) / 3)) begin
        errors++;
        $display("FAIL wait_cycle%0d: got req=%b vld=%b addr=%h, want 1 0 %h",
                 n, mem_req, instr_valid, mem_addr, 18'(20 + (n - 1) / 3));
      end
      mem_ack = (n % 3 == 0);
      tick();
    end
    mem_ack = 1'b0;
    checks++;
    if (instr_valid !== 1'b1 || instr !== exp_word(5)) begin
      errors++;
      $display("FAIL wait_instr: got vld=%b instr=%h, want 1 %h", instr_valid, instr, exp_word(5));
    end
    tick();
    checks++;
    if (instr_valid !== 1'b0) begin errors++; $display("FAIL wait_consume: got vld=%b, want 0", instr_valid); end
  endtask

  task automatic test_backpressure();
    bit ok;
    ip = 16'd9; mem_ack = 1'b1; instr_ready = 1'b0;
    wait_req(ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL bp_start: got no mem_req, want mem_req=1"); end
    for (int k = 0; k < 4; k++) tick();
    for (int i = 0; i < 10; i++) begin
      checks++;
      if (instr_valid !== 1'b1 || instr !== exp_word(9) || mem_req !== 1'b0) begin
        errors++;
        $display("FAIL bp_hold%0d: got vld=%b instr=%h req=%b, want 1 %h 0",
                 i, instr_valid, instr, mem_req, exp_word(9));
      end
      if (i == 5) ip = 16'd11;
      tick();
    end
    instr_ready = 1'b1;
    tick();
    checks++;
    if (instr_valid !== 1'b0 || mem_req !== 1'b0) begin
      errors++;
      $display("FAIL bp_release: got vld=%b req=%b, want 0 0", instr_valid, mem_req);
    end
    tick();
    checks++;
    if (mem_req !== 1'b1 || mem_addr !== 18'd44) begin
      errors++;
      $display("FAIL bp_next_addr: got req=%b addr=%h, want 1 %h", mem_req, mem_addr, 18'd44);
    end
    for (int k = 0; k < 4; k++) tick();
    checks++;
    if (instr_valid !== 1'b1 || instr !== exp_word(11)) begin
      errors++;
      $display("FAIL bp_next_instr: got vld=%b instr=%h, want 1 %h", instr_valid, instr, exp_word(11));
    end
    tick();
  endtask

  task automatic test_flush();
    bit ok;
    ip = 16'd3; mem_ack = 1'b1; instr_ready = 1'b1; flush = 1'b0;
    wait_req(ok);
    tick();
    tick();
    ip = 16'd7; flush = 1'b1;
    tick();
    checks++;
    if (mem_req !== 1'b0 || instr_valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL flush_abort: got req=%b vld=%b busy=%b, want 0 0 0", mem_req, instr_valid, busy);
    end
    flush = 1'b0; instr_ready = 1'b0;
    wait_req(ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL flush_restart: got no mem_req, want mem_req=1"); end
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (mem_addr !== 18'(28 + k)) begin
        errors++;
        $display("FAIL flush_addr%0d: got %h, want %h", k, mem_addr, 18'(28 + k));
      end
      tick();
    end
    checks++;
    if (instr_valid !== 1'b1 || instr !== exp_word(7)) begin
      errors++;
      $display("FAIL flush_instr: got vld=%b instr=%h, want 1 %h", instr_valid, instr, exp_word(7));
    end
    flush = 1'b1;
    tick();
    checks++;
    if (instr_valid !== 1'b0 || mem_req !== 1'b0) begin
      errors++;
      $display("FAIL flush_in_valid: got vld=%b req=%b, want 0 0", instr_valid, mem_req);
    end
    flush = 1'b0; instr_ready = 1'b1;
  endtask

  task automatic test_async_reset();
    bit ok;
    ip = 16'd2; mem_ack = 1'b1; instr_ready = 1'b0;
    wait_req(ok);
    tick();
    #2 rstn = 1'b0;
    #1;
    checks++;
    if ({mem_req, mem_addr, instr, instr_valid, busy, fault} !== '0) begin
      errors++;
      $display("FAIL areset_fetch: got req=%b addr=%h instr=%h vld=%b busy=%b, want all 0",
               mem_req, mem_addr, instr, instr_valid, busy);
    end
    ip = 16'd4;
    #1 rstn = 1'b1;
    wait_req(ok);
    checks++;
    if (!ok || mem_addr !== 18'd16) begin
      errors++;
      $display("FAIL areset_restart1: got req=%b addr=%h, want 1 %h", mem_req, mem_addr, 18'd16);
    end
    for (int k = 0; k < 4; k++) tick();
    checks++;
    if (instr_valid !== 1'b1 || instr !== exp_word(4)) begin
      errors++;
      $display("FAIL areset_instr: got vld=%b instr=%h, want 1 %h", instr_valid, instr, exp_word(4));
    end
    #2 rstn = 1'b0;
    #1;
    checks++;
    if ({mem_req, mem_addr, instr, instr_valid, busy, fault} !== '0) begin
      errors++;
      $display("FAIL areset_valid: got req=%b addr=%h instr=%h vld=%b busy=%b, want all 0",
               mem_req, mem_addr, instr, instr_valid, busy);
    end
    ip = 16'd6;
    #1 rstn = 1'b1;
    wait_req(ok);
    checks++;
    if (!ok || mem_addr !== 18'd24) begin
      errors++;
      $display("FAIL areset_restart2: got req=%b addr=%h, want 1 %h", mem_req, mem_addr, 18'd24);
    end
    instr_ready = 1'b1;
    for (int k = 0; k < 4; k++) tick();
    checks++;
    if (instr_valid !== 1'b1 || instr !== exp_word(6)) begin
      errors++;
      $display("FAIL areset_instr2: got vld=%b instr=%h, want 1 %h", instr_valid, instr, exp_word(6));
    end
    tick();
  endtask

  task automatic test_random();
    bit fetching = 1'b0;
    bit holding  = 1'b0;
    int k = 0;
    int fetch_ip = 0;
    int delivered = 0;
    int cyc = 0;
    while (delivered < 150 && cyc < 20000) begin
      checks++;
      if (mem_req !== fetching || busy !== fetching || instr_valid !== holding) begin
        errors++;
        $display("FAIL rand_ctrl@%0d: got req=%b busy=%b vld=%b, want %b %b %b",
                 cyc, mem_req, busy, instr_valid, fetching, fetching, holding);
      end
      if (fetching) begin
        checks++;
        if (mem_addr !== 18'(fetch_ip * 4 + k)) begin
          errors++;
          $display("FAIL rand_addr@%0d: got %h, want %h", cyc, mem_addr, 18'(fetch_ip * 4 + k));
        end
      end
      if (holding) begin
        checks++;
        if (instr !== exp_word(fetch_ip)) begin
          errors++;
          $display("FAIL rand_instr@%0d: got %h, want %h", cyc, instr, exp_word(fetch_ip));
        end
      end
      ip          = 16'($urandom_range(0, 255));
      flush       = (fetching || holding) && ($urandom_range(0, 24) == 0);
      mem_ack     = ($urandom_range(0, 1) == 1);
      instr_ready = ($urandom_range(0, 2) != 0);
      if (!fetching && !holding) begin
        fetching = 1'b1;
        k = 0;
        fetch_ip = int'(ip);
      end else if (flush) begin
        fetching = 1'b0;
        holding  = 1'b0;
      end else if (fetching && mem_ack) begin
        if (k == 3) begin
          fetching = 1'b0;
          holding  = 1'b1;
          k = 0;
        end else begin
          k++;
        end
      end else if (holding && instr_ready) begin
        holding = 1'b0;
        delivered++;
      end
      tick();
      cyc++;
    end
    flush = 1'b0;
    checks++;
    if (delivered < 150) begin
      errors++;
      $display("FAIL rand_progress: got %0d instructions, want 150", delivered);
    end
  endtask

  task automatic test_fault();
    bit ok;
    ip = 16'd256; mem_ack = 1'b1; instr_ready = 1'b1; flush = 1'b0;
    checks++;
    if (fault !== 1'b0) begin errors++; $display("FAIL fault_pre: got %b, want 0", fault); end
    tick();
    checks++;
    if (fault !== 1'b1 || mem_req !== 1'b0) begin
      errors++;
      $display("FAIL fault_set: got fault=%b req=%b, want 1 0", fault, mem_req);
    end
    for (int i = 0; i < 20; i++) begin
      ip      = 16'($urandom_range(0, 300));
      flush   = ($urandom_range(0, 1) == 1);
      mem_ack = ($urandom_range(0, 1) == 1);
      tick();
      checks++;
      if (fault !== 1'b1 || mem_req !== 1'b0 || instr_valid !== 1'b0 || busy !== 1'b0) begin
        errors++;
        $display("FAIL fault_sticky%0d: got fault=%b req=%b vld=%b busy=%b, want 1 0 0 0",
                 i, fault, mem_req, instr_valid, busy);
      end
    end
    #2 rstn = 1'b0;
    #1;
    checks++;
    if (fault !== 1'b0) begin errors++; $display("FAIL fault_clear: got %b, want 0", fault); end
    ip = 16'd1; flush = 1'b0; mem_ack = 1'b1;
    #1 rstn = 1'b1;
    wait_req(ok);
    checks++;
    if (!ok || mem_addr !== 18'd4) begin
      errors++;
      $display("FAIL fault_recover: got req=%b addr=%h, want 1 %h", mem_req, mem_addr, 18'd4);
    end
    for (int k = 0; k < 4; k++) tick();
    checks++;
    if (instr_valid !== 1'b1 || instr !== exp_word(1)) begin
      errors++;
      $display("FAIL fault_recover_instr: got vld=%b instr=%h, want 1 %h", instr_valid, instr, exp_word(1));
    end
    tick();
  endtask

  initial begin
    errors = 0;
    checks = 0;
    for (int a = 0; a < 1024; a++) mem[a] = 8'($urandom);
    mem[0] = 8'h12; mem[1] = 8'h34; mem[2] = 8'h56; mem[3] = 8'h78;
    test_reset();
    test_basic();
    test_wait_states();
    test_backpressure();
    test_flush();
    test_async_reset();
    test_random();
    test_fault();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
